// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM arbiter: FSM state and owner encodings,
// the default byte-address width and the byte returned when a transaction
// is abandoned after a timeout.
package sdram_pkg;

  localparam int AW_DEF = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_t;

  localparam logic [7:0] RD_FILL = 8'hFF;

endpackage

// File: rtl/sdram_arb_burst.sv
// Video burst tracker: latches the start address and length of a line fetch,
// advances one byte per completed video beat and flags the last beat.
//   clock, reset      : clock, asynchronous active-high reset
//   vid_start         : one-cycle burst start, ignored while a burst runs
//   vid_addr, vid_len : burst start address and length (0 = 256 bytes)
//   beat              : a video transaction completed this cycle
//   burst_addr        : address of the next video byte
//   vid_busy          : burst in progress
//   vid_done          : one-cycle pulse registered with the final beat
module sdram_arb_burst
  import sdram_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          vid_start,
  input  logic [AW-1:0] vid_addr,
  input  logic [7:0]    vid_len,
  input  logic          beat,
  output logic [AW-1:0] burst_addr,
  output logic          vid_busy,
  output logic          vid_done
);

  // Nine bits so that a length of 0 can stand for a full 256-byte burst.
  logic [8:0] burst_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      burst_addr <= '0;
      burst_cnt  <= '0;
      vid_busy   <= 1'b0;
      vid_done   <= 1'b0;
    end else begin
      vid_done <= 1'b0;
      if (!vid_busy) begin
        if (vid_start) begin
          burst_addr <= vid_addr;
          burst_cnt  <= (vid_len == 8'd0) ? 9'd256 : {1'b0, vid_len};
          vid_busy   <= 1'b1;
        end
      end else if (beat) begin
        // Address wraps naturally modulo 2^AW.
        burst_addr <= burst_addr + 1'b1;
        burst_cnt  <= burst_cnt - 1'b1;
        if (burst_cnt == 9'd1) begin
          vid_busy <= 1'b0;
          vid_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbiter sharing the single-port SDRAM byte controller between the CPU
// (random byte reads/writes) and the video line fetcher (read bursts).
// One byte transaction is in flight at a time; video wins contention, but
// after CPU_SLOT consecutive video beats with the CPU waiting, the CPU is
// served. A stuck transaction is abandoned after TMO cycles and flagged.
//   clock, reset                 : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata        : CPU request (level, held until cpu_ack)
//   cpu_rdata, cpu_ack           : CPU read data with one-cycle completion
//   vid_start/addr/len           : burst start pulse, address, length
//   vid_valid/data/done/busy     : per-byte delivery, last-byte pulse, busy
//   m_mreq/read/write/address/wdata : request to the SDRAM controller
//   m_rdata, m_done              : controller read data and completion
//   err                          : sticky timeout flag
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int CPU_SLOT = 4,
  parameter int TMO      = 1023
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_ack,
  input  logic          vid_start,
  input  logic [AW-1:0] vid_addr,
  input  logic [7:0]    vid_len,
  output logic          vid_valid,
  output logic [7:0]    vid_data,
  output logic          vid_done,
  output logic          vid_busy,
  output logic          m_mreq,
  output logic          m_read,
  output logic          m_write,
  output logic [AW-1:0] m_address,
  output logic [7:0]    m_wdata,
  input  logic [7:0]    m_rdata,
  input  logic          m_done,
  output logic          err
);

  localparam int SW = $clog2(CPU_SLOT + 1);
  localparam int TW = $clog2(TMO + 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(CPU_SLOT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  state_t        state;
  owner_t        owner;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [AW-1:0] burst_addr;
  logic          tmo_hit;
  logic          finish;
  logic          vid_beat;
  logic          cpu_win;
  logic [7:0]    done_data;

  // The counter reaches TMO on the edge where it would step past TMO-1.
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign finish    = (state == ST_BUSY) && (m_done || tmo_hit);
  assign vid_beat  = finish && (owner == OWN_VID);
  // A genuine completion wins over a coincident timeout.
  assign done_data = m_done ? m_rdata : RD_FILL;
  assign cpu_win   = cpu_req && (!vid_busy || (starve_cnt >= SLOT_MAX));

  sdram_arb_burst #(.AW(AW)) u_burst (
    .clock      (clock),
    .reset      (reset),
    .vid_start  (vid_start),
    .vid_addr   (vid_addr),
    .vid_len    (vid_len),
    .beat       (vid_beat),
    .burst_addr (burst_addr),
    .vid_busy   (vid_busy),
    .vid_done   (vid_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= OWN_CPU;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      vid_valid  <= 1'b0;
      vid_data   <= '0;
      m_mreq     <= 1'b0;
      m_read     <= 1'b0;
      m_write    <= 1'b0;
      m_address  <= '0;
      m_wdata    <= '0;
      err        <= 1'b0;
    end else begin
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_win) begin
            owner      <= OWN_CPU;
            m_mreq     <= 1'b1;
            m_write    <= cpu_we;
            m_read     <= ~cpu_we;
            m_address  <= cpu_addr;
            m_wdata    <= cpu_wdata;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            state      <= ST_BUSY;
          end else if (vid_busy) begin
            owner     <= OWN_VID;
            m_mreq    <= 1'b1;
            m_read    <= 1'b1;
            m_write   <= 1'b0;
            m_address <= burst_addr;
            tmo_cnt   <= '0;
            state     <= ST_BUSY;
            // Only beats that keep a waiting CPU out count towards its slot.
            if (cpu_req && (starve_cnt < SLOT_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ST_BUSY: begin
          if (finish) begin
            m_mreq  <= 1'b0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            state   <= ST_GAP;
            if (!m_done)
              err <= 1'b1;
            if (owner == OWN_CPU) begin
              cpu_rdata <= done_data;
              cpu_ack   <= 1'b1;
            end else begin
              vid_data  <= done_data;
              vid_valid <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        // One idle cycle so the controller sees m_mreq drop.
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single-port SDRAM byte controller between two requesters: the CPU (random byte read/write) and the video line fetcher (sequential read bursts).
- Sits between the requesters and the controller's mreq/read/write/address port.
- Issues one byte transaction at a time and waits for the controller's completion strobe.
- Video has priority, but a starvation counter guarantees the CPU a slot every CPU_SLOT video beats.

Parameters:
- AW, 26, SDRAM byte address width.
- CPU_SLOT, 4, maximum consecutive video beats granted while cpu_req is pending.
- TMO, 1023, cycles in BUSY without m_done before the transaction is aborted.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  level; held until cpu_ack
- cpu_we  in  1  1=write, 0=read; valid while cpu_req
- cpu_addr  in  AW  byte address
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- vid_start  in  1  one-cycle pulse, starts a burst
- vid_addr  in  AW  burst start address, sampled with vid_start
- vid_len  in  8  burst length in bytes; 0 means 256
- vid_valid  out  1  one-cycle pulse per delivered byte
- vid_data  out  8  byte, valid with vid_valid
- vid_done  out  1  one-cycle pulse with the last vid_valid
- vid_busy  out  1  burst in progress
- m_mreq  out  1  request to controller
- m_read  out  1  read strobe
- m_write  out  1  write strobe
- m_address  out  AW  address to controller
- m_wdata  out  8  write data to controller
- m_rdata  in  8  read data, valid with m_done
- m_done  in  1  one-cycle completion pulse from controller
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; burst address, burst count, starvation counter and timeout counter all 0.
- States: IDLE -> BUSY -> GAP -> IDLE.
- IDLE, grant selection:
  - vid_busy and cpu_req both pending: grant CPU if starve_cnt >= CPU_SLOT, otherwise grant video.
  - Only one pending: grant that one.
  - Neither pending: stay in IDLE.
- IDLE, on grant (edge N): drive m_mreq=1 at N+1, with m_read/m_write/m_address/m_wdata registered; go to BUSY.
- CPU grant: m_write=cpu_we, m_read=~cpu_we; starve_cnt cleared.
- Video grant: m_read=1, m_address=burst address; starve_cnt+1 if cpu_req=1, saturating at CPU_SLOT.
- BUSY:
  - All m_* outputs held stable; timeout counter increments each cycle.
  - On m_done: m_mreq/m_read/m_write cleared at the same edge; owner pulse asserted for one cycle; go to GAP.
  - CPU owner: cpu_rdata<=m_rdata (writes also update it), cpu_ack=1.
  - Video owner: vid_data<=m_rdata, vid_valid=1, burst address +1 (wraps modulo 2^AW), count -1.
  - When count reaches 0: vid_done=1 together with vid_valid; vid_busy falls at the same edge.
- GAP: exactly one cycle with m_mreq=0, so the controller sees the request drop. The CPU must deassert cpu_req in this cycle. cpu_req is next sampled in IDLE, 2 cycles after the ack edge.
- Timeout: if the counter reaches TMO in BUSY:
  - Drop m_mreq and set err=1; err is cleared only by reset.
  - Complete the transaction as if m_done arrived, with data 8'hFF, so no requester deadlocks.
  - The counter clears on each new grant.
- vid_start while vid_busy=1: ignored. vid_start in the same cycle as a grant decision is latched; it competes only from the next IDLE.
- m_done outside BUSY: ignored.
- Minimum CPU transaction latency: req edge N -> m_mreq N+1 -> ack = m_done edge +0.

Decomposition:
- Shared package (sdram_pkg):
  - state encoding localparams ST_IDLE/ST_BUSY/ST_GAP;
  - owner encoding OWN_CPU/OWN_VID;
  - AW default;
  - read-fill value 8'hFF.
- One natural sub-module: sdram_arb_burst, holding the video burst address/count registers and generating vid_busy/vid_done.

Test Plan:
- CPU read alone:
  - stimulus: cpu_req=1, cpu_we=0, cpu_addr=26'h0001234; model m_done 8 cycles after m_mreq with m_rdata=8'h5A;
  - response: m_address=26'h0001234, m_read=1; cpu_ack one cycle with cpu_rdata=8'h5A; m_mreq low during GAP.
- CPU write:
  - stimulus: cpu_we=1, cpu_wdata=8'hC3, cpu_addr=26'h3FFFFFF;
  - response: m_write=1, m_wdata=8'hC3, m_read=0; single cpu_ack.
- Video burst with wrap:
  - stimulus: vid_start with vid_addr=26'h3FFFFFE, vid_len=4;
  - response: m_address sequence 3FFFFFE, 3FFFFFF, 0000000, 0000001; 4 vid_valid; vid_done with the 4th; vid_busy low afterwards.
- Contention:
  - stimulus: burst vid_len=0 (256) with cpu_req held high;
  - response: exactly 4 video beats, then 1 CPU grant, repeating; no video beat lost; total vid_valid=256.
- Timeout:
  - stimulus: m_done never asserted on a CPU read;
  - response: after 1023 BUSY cycles m_mreq=0, err=1, cpu_ack with cpu_rdata=8'hFF; a following transaction completes normally with err still 1.
- Reset mid-burst:
  - stimulus: assert reset during BUSY;
  - response: all outputs 0 immediately (asynchronous), vid_busy=0; after release, IDLE accepts a new vid_start.
